// File: rtl/msrv32_imm_gen_if.sv
// Immediate-generator bus: decoder side (master) supplies instruction bits and
// format code, the generator (slave) returns the registered immediate.
interface msrv32_imm_gen_if;
  logic [31:7] instr;
  logic [2:0]  imm_type_in;
  logic [31:0] imm_out;

  modport master (
    output instr,
    output imm_type_in,
    input  imm_out
  );

  modport slave (
    input  instr,
    input  imm_type_in,
    output imm_out
  );
endinterface

// File: rtl/msrv32_imm_gen.sv
// RV32I immediate generator: builds the I/S/B/U/J (and optional CSR zimm)
// immediate and registers it once. Optional macro: MSRV32_IMM_CSR_EN.
module msrv32_imm_gen (
  input  logic                    ms_riscv32_mp_clk_in,
  input  logic                    ms_riscv32_mp_rst_in,
  msrv32_imm_gen_if.slave         bus
);

  logic [31:0] imm_next;
  logic        sign;

  assign sign = bus.instr[31];

  always_comb begin
    imm_next = 32'h0000_0000;
    case (bus.imm_type_in)
      3'b010:  imm_next = {{20{sign}}, bus.instr[31:25], bus.instr[11:7]};
      3'b011:  imm_next = {{20{sign}}, bus.instr[7], bus.instr[30:25],
                           bus.instr[11:8], 1'b0};
      3'b100:  imm_next = {bus.instr[31:12], 12'h000};
      3'b101:  imm_next = {{12{sign}}, bus.instr[19:12], bus.instr[20],
                           bus.instr[30:21], 1'b0};
`ifdef MSRV32_IMM_CSR_EN
      3'b110:  imm_next = {27'b0, bus.instr[19:15]};
`else
      3'b110:  imm_next = 32'h0000_0000;
`endif
      // 000, 001 and 111 all select the I-type immediate.
      default: imm_next = {{20{sign}}, bus.instr[31:20]};
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) bus.imm_out <= 32'h0000_0000;
    else                      bus.imm_out <= imm_next;
  end

endmodule

// File: tb/tb_msrv32_imm_gen.sv
// Scoreboard bench for msrv32_imm_gen: directed vectors plus a low-field sweep.
module tb_msrv32_imm_gen;

  logic clk;
  logic rst;
  msrv32_imm_gen_if bus ();

  msrv32_imm_gen dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .bus                  (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] exp_q[$];
  string       name_q[$];
  int          n_checks;
  int          n_fail;
  bit          drive_done;

  // Reference immediate, written from the ISA bit layout of a full 32-bit word.
  function automatic logic [31:0] ref_imm(input logic [31:0] w, input logic [2:0] t);
    logic [31:0] r;
    logic [31:0] sx;
    sx = w[31] ? 32'hFFFF_FFFF : 32'h0;
    case (t)
      3'd2: r = (sx & 32'hFFFF_F800) | ({20'b0, w[31:25], 5'b0}) | {27'b0, w[11:7]};
      3'd3: r = (sx & 32'hFFFF_F000) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5)
                | (32'(w[11:8]) << 1);
      3'd4: r = w & 32'hFFFF_F000;
      3'd5: r = (sx & 32'hFFF0_0000) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11)
                | (32'(w[30:21]) << 1);
`ifdef MSRV32_IMM_CSR_EN
      3'd6: r = 32'(w[19:15]);
`else
      3'd6: r = 32'h0;
`endif
      default: r = (sx & 32'hFFFF_F000) | 32'(w[31:20]);
    endcase
    return r;
  endfunction

  // driver: apply inputs mid-cycle and log the value expected after the next edge
  task automatic apply(input logic r, input logic [31:0] w, input logic [2:0] t,
                       input logic [31:0] exp, input string nm);
    @(negedge clk);
    rst             = r;
    bus.instr       = w[31:7];
    bus.imm_type_in = t;
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  // monitor: every edge produces a new imm_out, compared just after the edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [31:0] e;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if (bus.imm_out !== e) begin
        n_fail++;
        $display("FAIL %s: imm_out=%08h expected=%08h", nm, bus.imm_out, e);
      end
    end
  end

  initial begin
    logic [31:0] w;
    logic [31:0] hi;
    n_checks        = 0;
    n_fail          = 0;
    drive_done      = 1'b0;
    rst             = 1'b1;
    bus.instr       = '0;
    bus.imm_type_in = '0;

    // reset holds zero even with an all-ones U-type input present
    for (int i = 0; i < 3; i++) apply(1'b1, 32'hFFFF_FF80, 3'd4, 32'h0, "reset_hold");
    apply(1'b0, 32'hFFFF_FF80, 3'd4, 32'hFFFF_F000, "reset_release");

    apply(1'b0, 32'hFFF0_0000, 3'd0, 32'hFFFF_FFFF, "i_type_000");
    apply(1'b0, 32'hFFF0_0000, 3'd1, 32'hFFFF_FFFF, "i_type_001");
    apply(1'b0, 32'hFFF0_0000, 3'd7, 32'hFFFF_FFFF, "i_type_111");
    apply(1'b0, 32'h07F0_0000, 3'd0, 32'h0000_007F, "i_type_pos");
    apply(1'b0, 32'h0000_0A80, 3'd2, 32'h0000_0015, "s_type");
    apply(1'b0, 32'h0000_0A80, 3'd3, 32'h0000_0814, "b_type");
    apply(1'b0, 32'h8010_0000, 3'd5, 32'hFFF0_0800, "j_type");
    apply(1'b0, 32'h1234_5F80, 3'd4, 32'h1234_5000, "u_type");
`ifdef MSRV32_IMM_CSR_EN
    apply(1'b0, 32'h800F_8000, 3'd6, 32'h0000_001F, "csr_zimm");
`else
    apply(1'b0, 32'h800F_8000, 3'd6, 32'h0000_0000, "csr_zimm");
`endif
    // mid-run reset overrides the datapath
    apply(1'b1, 32'hFFF0_0000, 3'd0, 32'h0, "reset_mid");

    // sweep instr[12:7] under several upper-bit backgrounds, all codes
    for (int b = 0; b < 4; b++) begin
      case (b)
        0:       hi = 32'h0000_0000;
        1:       hi = 32'hFFFF_E000;
        2:       hi = 32'h5555_4000;
        default: hi = {$urandom_range(0, 32'h7FFFF), 13'b0};
      endcase
      for (int t = 0; t < 8; t++)
        for (int f = 0; f < 64; f++) begin
          w = hi | (32'(f) << 7);
          apply(1'b0, w, 3'(t), ref_imm(w, 3'(t)), "sweep");
        end
    end

    drive_done = 1'b1;
    // bounded drain of the scoreboard
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
